taxi_mmcm_rst_ctrl: RTL and testbench

- Reset and lock supervisor for an MMCM/PLL. It drives the MMCM RST input, which the board top levels currently tie low.
- Issues a power-on reset pulse, waits for lock with a timeout, and retries on failure.
- Qualifies lock as stable before asserting ready. Detects lock loss and re-runs the sequence.
- Runs on the free-running input reference clock, ahead of the MMCM. Its ready output feeds the downstream reset synchronizers.

---
 rtl/taxi_mmcm_rst_ctrl_pkg.sv | 17 +
 rtl/taxi_mmcm_rst_ctrl_sync.sv | 25 ++
 rtl/taxi_mmcm_rst_ctrl.sv | 150 +++++++++++++++
 tb/tb_taxi_mmcm_rst_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/taxi_mmcm_rst_ctrl_pkg.sv
// Shared types and helpers for the MMCM reset/lock supervisor.
package taxi_mmcm_rst_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_ASSERT = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAIL       = 3'd4
    } state_e;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic [15:0] max_val);
        return (val >= max_val) ? max_val : val + 16'd1;
    endfunction

endpackage

// File: rtl/taxi_mmcm_rst_ctrl_sync.sv
// Two-flop synchronizer with asynchronous active-low clear.
module taxi_mmcm_rst_ctrl_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    // Resample the asynchronous input twice to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/taxi_mmcm_rst_ctrl.sv
// MMCM/PLL reset and lock supervisor: pulses RST, waits for lock with a
// timeout, qualifies lock as stable, retries on failure and restarts on
// lock loss. Runs on the free-running reference clock.
module taxi_mmcm_rst_ctrl
    import taxi_mmcm_rst_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RETRY_LIMIT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mmcm_locked,
    input  logic        req_reset,
    output logic        mmcm_rst,
    output logic        ready,
    output logic        fail,
    output logic [7:0]  retry_count,
    output logic [15:0] lock_loss_count
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    // A limit above 255 can never be reached by the saturating 8-bit count.
    localparam bit LIM_EN  = (RETRY_LIMIT != 0) && (RETRY_LIMIT <= 255);
    localparam logic [7:0] LIM8 = LIM_EN ? 8'(RETRY_LIMIT) : 8'd0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         retry_q, retry_d;
    logic [15:0]        loss_q, loss_d;
    logic               mmcm_rst_q, mmcm_rst_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               attempt_fail;
    logic               locked_s;

    taxi_mmcm_rst_ctrl_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mmcm_locked),
        .q_o   (locked_s)
    );

    // Next-state, counter and status-counter logic; req_reset overrides all.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        loss_d       = loss_q;
        attempt_fail = 1'b0;

        if (req_reset) begin
            state_d = RST_ASSERT;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_ASSERT: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        attempt_fail = 1'b1;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        loss_d  = sat_inc(loss_q, 16'hFFFF);
                        state_d = RST_ASSERT;
                        cnt_d   = '0;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_ASSERT;
                    cnt_d   = '0;
                end
            endcase

            // A failed attempt either retries or gives up at the limit.
            if (attempt_fail) begin
                retry_d = 8'(sat_inc({8'd0, retry_q}, 16'd255));
                cnt_d   = '0;
                if (LIM_EN && (retry_d >= LIM8)) begin
                    state_d = FAIL;
                end else begin
                    state_d = RST_ASSERT;
                end
            end
        end

        mmcm_rst_d = (state_d == RST_ASSERT) || (state_d == FAIL);
        ready_d    = (state_d == RUN);
        fail_d     = (state_d == FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_ASSERT;
            cnt_q      <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            mmcm_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            mmcm_rst_q <= mmcm_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign mmcm_rst        = mmcm_rst_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_taxi_mmcm_rst_ctrl.sv
// Scoreboard bench for taxi_mmcm_rst_ctrl: stimulus queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_taxi_mmcm_rst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mmcm_locked;
    logic        req_reset;
    logic        mmcm_rst;
    logic        ready;
    logic        fail;
    logic [7:0]  retry_count;
    logic [15:0] lock_loss_count;

    taxi_mmcm_rst_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .RETRY_LIMIT   (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mmcm_locked     (mmcm_locked),
        .req_reset       (req_reset),
        .mmcm_rst        (mmcm_rst),
        .ready           (ready),
        .fail            (fail),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int          cyc;
        logic        rst;
        logic        rdy;
        logic        fl;
        logic [7:0]  rc;
        logic [15:0] ll;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic push(input int c, input logic r, input logic rd, input logic f,
                        input logic [7:0] rc, input logic [15:0] ll, input string nm);
        exp_t e;
        e.cyc = c; e.rst = r; e.rdy = rd; e.fl = f; e.rc = rc; e.ll = ll; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input logic r, input logic rd, input logic f,
                         input logic [7:0] rc, input logic [15:0] ll);
        n_vec++;
        if (mmcm_rst !== r || ready !== rd || fail !== f ||
            retry_count !== rc || lock_loss_count !== ll) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got rst=%b rdy=%b fail=%b retry=%0d loss=%0d, want rst=%b rdy=%b fail=%b retry=%0d loss=%0d",
                     nm, cyc, mmcm_rst, ready, fail, retry_count, lock_loss_count,
                     r, rd, f, rc, ll);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every checkpoint due at this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s: checkpoint for cycle %0d not taken, now cycle %0d", e.name, e.cyc, cyc);
            end else begin
                check(e.name, e.rst, e.rdy, e.fl, e.rc, e.ll);
            end
        end
    end

    // Monitor: reset must act without a clock edge.
    always @(negedge rst_n) begin
        #1;
        check("async_reset", 1'b1, 1'b0, 1'b0, 8'd0, 16'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int R, L, D, L2, Q, D3, P, E, F;

    initial begin
        rst_n = 1'b1; mmcm_locked = 1'b0; req_reset = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        push(cyc, 1, 0, 0, 0, 0, "reset_hold");

        // 1: power-on pulse, then lock 10 cycles after mmcm_rst falls
        rst_n = 1'b1; R = cyc;
        push(R + 3, 1, 0, 0, 0, 0, "s1_rst_hi");
        push(R + 4, 0, 0, 0, 0, 0, "s1_rst_lo");
        tick(14); L = cyc; mmcm_locked = 1'b1;
        push(L + 10, 0, 0, 0, 0, 0, "s1_rdy_pre");
        push(L + 11, 0, 1, 0, 0, 0, "s1_rdy_rise");
        tick(16);

        // 3: lock loss in RUN for 5 cycles
        D = cyc; mmcm_locked = 1'b0;
        push(D + 2, 0, 1, 0, 0, 0, "s3_rdy_hold");
        push(D + 3, 1, 0, 0, 0, 1, "s3_rdy_drop");
        push(D + 6, 1, 0, 0, 0, 1, "s3_rst_hi");
        push(D + 7, 0, 0, 0, 0, 1, "s3_rst_lo");
        tick(5); L2 = cyc; mmcm_locked = 1'b1;
        push(L2 + 10, 0, 0, 0, 0, 1, "s3_rdy_pre");
        push(L2 + 11, 0, 1, 0, 0, 1, "s3_rdy_back");
        tick(11);

        // 4: req_reset from RUN, then a 1-cycle glitch at STABLE count 5
        Q = cyc;
        for (int k = 1; k <= 25; k++) begin
            push(Q + k, (k <= 4) || (k >= 12 && k <= 15), (k == 25), 1'b0,
                 (k >= 12 && k <= 24) ? 8'd1 : 8'd0, 16'd1, "s4_glitch_seq");
        end
        req_reset = 1'b1;
        tick(1); req_reset = 1'b0;
        tick(8); mmcm_locked = 1'b0;
        tick(1); mmcm_locked = 1'b1;
        tick(15);

        // 2: lock lost and never returns -> retries exhaust into FAIL
        D3 = cyc; mmcm_locked = 1'b0;
        push(D3 + 2,   0, 1, 0, 0, 1, "s2_run");
        push(D3 + 3,   1, 0, 0, 0, 2, "s2_pulse1");
        push(D3 + 6,   1, 0, 0, 0, 2, "s2_pulse1_end");
        push(D3 + 7,   0, 0, 0, 0, 2, "s2_wait1");
        push(D3 + 38,  0, 0, 0, 0, 2, "s2_wait1_end");
        push(D3 + 39,  1, 0, 0, 1, 2, "s2_pulse2");
        push(D3 + 42,  1, 0, 0, 1, 2, "s2_pulse2_end");
        push(D3 + 43,  0, 0, 0, 1, 2, "s2_wait2");
        push(D3 + 74,  0, 0, 0, 1, 2, "s2_wait2_end");
        push(D3 + 75,  1, 0, 0, 2, 2, "s2_pulse3");
        push(D3 + 78,  1, 0, 0, 2, 2, "s2_pulse3_end");
        push(D3 + 79,  0, 0, 0, 2, 2, "s2_wait3");
        push(D3 + 110, 0, 0, 0, 2, 2, "s2_wait3_end");
        push(D3 + 111, 1, 0, 1, 3, 2, "s2_fail");
        push(D3 + 119, 1, 0, 1, 3, 2, "s2_fail_held");
        tick(120);

        // 5: req_reset out of FAIL
        P = cyc;
        push(P,     1, 0, 1, 3, 2, "s5_in_fail");
        push(P + 1, 1, 0, 0, 0, 2, "s5_cleared");
        push(P + 4, 1, 0, 0, 0, 2, "s5_rst_end");
        push(P + 5, 0, 0, 0, 0, 2, "s5_wait_lock");
        push(P + 9, 0, 0, 0, 0, 2, "s5_wait_mid");
        req_reset = 1'b1;
        tick(1); req_reset = 1'b0;
        tick(9);

        // 6a: rst_n mid-WAIT_LOCK
        push(cyc,     1, 0, 0, 0, 0, "s6_rst_low0");
        push(cyc + 1, 1, 0, 0, 0, 0, "s6_rst_low1");
        rst_n = 1'b0;
        tick(2);
        E = cyc; rst_n = 1'b1; mmcm_locked = 1'b1;
        push(E,      1, 0, 0, 0, 0, "s6_release");
        push(E + 3,  1, 0, 0, 0, 0, "s6_rst_hi");
        push(E + 4,  0, 0, 0, 0, 0, "s6_rst_lo");
        push(E + 12, 0, 0, 0, 0, 0, "s6_rdy_pre");
        push(E + 13, 0, 1, 0, 0, 0, "s6_rdy_rise");
        tick(16);

        // 6b: req_reset coincides with a RUN lock loss
        F = cyc; mmcm_locked = 1'b0;
        push(F + 2, 0, 1, 0, 0, 0, "s6b_run");
        push(F + 3, 1, 0, 0, 0, 0, "s6b_req_wins");
        push(F + 7, 0, 0, 0, 0, 0, "s6b_wait");
        tick(2); req_reset = 1'b1;
        tick(1); req_reset = 1'b0;
        tick(8);

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: %0d checkpoints left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
